// File: rtl/shell_bus_pkg.sv
// Shared types for the shell bus responder.
// State encoding, bus select encoding and bus width.
package shell_bus_pkg;

   localparam int BUS_W = 16;

   localparam logic SEL_ROM = 1'b0;
   localparam logic SEL_RAM = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HALT_WAIT,
      ST_ACCESS,
      ST_READ_WAIT,
      ST_RESP
   } state_t;

   typedef struct packed {
      logic             wr;
      logic             sel;
      logic [BUS_W-1:0] addr;
      logic [BUS_W-1:0] data;
   } req_t;

endpackage

// File: rtl/shell_bus_timer.sv
// Halt-acknowledge watchdog: load, count down, expire.
// Only instantiated when SHELL_BUS_TIMEOUT_EN is defined.
module shell_bus_timer
   import shell_bus_pkg::*;
#(
   parameter int CYCLES = 1024
) (
   input  logic CLK,
   input  logic RST,
   input  logic i_Load,
   input  logic i_Count,
   output logic o_Expire
);

   localparam int W = $clog2(CYCLES) + 1;

   logic [W-1:0] cnt_q;

   // Load with CYCLES-1 so expiry lands on the last allowed wait cycle
   always_ff @(posedge CLK) begin
      if (!RST) begin
         cnt_q <= '0;
      end else if (i_Load) begin
         cnt_q <= W'(CYCLES - 1);
      end else if (i_Count && cnt_q != '0) begin
         cnt_q <= cnt_q - W'(1);
      end
   end

   assign o_Expire = (cnt_q == '0);

endmodule

// File: rtl/shell_bus_responder.sv
// Shell bus responder: halts the Hack CPU and performs one ROM/RAM access.
// Optional halt-ack timeout enabled with `define SHELL_BUS_TIMEOUT_EN.
module shell_bus_responder
   import shell_bus_pkg::*;
#(
   parameter int RD_LATENCY     = 1,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        i_Bus_CS,
   input  logic        i_Bus_Wr_Rd_n,
   input  logic        i_Bus_Sel,
   input  logic [15:0] i_Bus_Addr,
   input  logic [15:0] i_Bus_Wr_Data,
   output logic        o_Bus_Busy,
   output logic        o_Bus_Rd_DV,
   output logic [15:0] o_Bus_Rd_Data,
   output logic        o_Bus_Wr_Done,
   output logic        o_Bus_Err,
   output logic        o_Halt_Req,
   input  logic        i_Halt_Ack,
   output logic [15:0] o_Mem_Addr,
   output logic [15:0] o_Mem_Wr_Data,
   output logic        o_ROM_We,
   output logic        o_RAM_We,
   output logic        o_Mem_Re,
   input  logic [15:0] i_Mem_Rd_Data
);

   state_t     state_q;
   state_t     state_d;
   req_t       req_q;
   logic [2:0] rd_cnt_q;
   logic [15:0] rd_data_q;
   logic       expire;
   logic       resp_err;
   logic       accept;

   assign accept = (state_q == ST_IDLE) && i_Bus_CS;

`ifdef SHELL_BUS_TIMEOUT_EN
   logic err_q;

   shell_bus_timer #(
      .CYCLES (TIMEOUT_CYCLES)
   ) u_timer (
      .CLK      (CLK),
      .RST      (RST),
      .i_Load   (accept),
      .i_Count  (state_q == ST_HALT_WAIT),
      .o_Expire (expire)
   );

   // Remember that RESP was reached by timeout rather than by an access
   always_ff @(posedge CLK) begin
      if (!RST) begin
         err_q <= 1'b0;
      end else if (state_q == ST_HALT_WAIT) begin
         err_q <= !i_Halt_Ack && expire;
      end else if (state_q == ST_IDLE) begin
         err_q <= 1'b0;
      end
   end

   assign resp_err = err_q;
`else
   assign expire   = 1'b0;
   assign resp_err = 1'b0;
`endif

   // State register
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Capture the request only when it is accepted from IDLE
   always_ff @(posedge CLK) begin
      if (!RST) begin
         req_q <= '0;
      end else if (accept) begin
         req_q.wr   <= i_Bus_Wr_Rd_n;
         req_q.sel  <= i_Bus_Sel;
         req_q.addr <= i_Bus_Addr;
         req_q.data <= i_Bus_Wr_Data;
      end
   end

   // Read latency counter: loaded in ACCESS, runs down in READ_WAIT
   always_ff @(posedge CLK) begin
      if (!RST) begin
         rd_cnt_q <= '0;
      end else if (state_q == ST_ACCESS) begin
         rd_cnt_q <= 3'(RD_LATENCY - 1);
      end else if (state_q == ST_READ_WAIT && rd_cnt_q != '0) begin
         rd_cnt_q <= rd_cnt_q - 3'd1;
      end
   end

   // Latch memory data on the last READ_WAIT cycle; held otherwise
   always_ff @(posedge CLK) begin
      if (!RST) begin
         rd_data_q <= '0;
      end else if (state_q == ST_READ_WAIT && rd_cnt_q == '0) begin
         rd_data_q <= i_Mem_Rd_Data;
      end
   end

   // Next-state and strobe decode
   always_comb begin
      state_d       = state_q;
      o_Bus_Busy    = (state_q != ST_IDLE);
      o_Halt_Req    = 1'b0;
      o_ROM_We      = 1'b0;
      o_RAM_We      = 1'b0;
      o_Mem_Re      = 1'b0;
      o_Bus_Wr_Done = 1'b0;
      o_Bus_Rd_DV   = 1'b0;
      o_Bus_Err     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (i_Bus_CS) state_d = ST_HALT_WAIT;
         end
         ST_HALT_WAIT: begin
            o_Halt_Req = 1'b1;
            if (i_Halt_Ack) state_d = ST_ACCESS;
            else if (expire) state_d = ST_RESP;
         end
         ST_ACCESS: begin
            o_Halt_Req = 1'b1;
            if (req_q.wr) begin
               o_ROM_We = (req_q.sel == SEL_ROM);
               o_RAM_We = (req_q.sel == SEL_RAM);
               state_d  = ST_RESP;
            end else begin
               o_Mem_Re = 1'b1;
               state_d  = ST_READ_WAIT;
            end
         end
         ST_READ_WAIT: begin
            o_Halt_Req = 1'b1;
            if (rd_cnt_q == '0) state_d = ST_RESP;
         end
         ST_RESP: begin
            o_Bus_Err     = resp_err;
            o_Bus_Wr_Done = req_q.wr && !resp_err;
            o_Bus_Rd_DV   = !req_q.wr && !resp_err;
            state_d       = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign o_Mem_Addr    = req_q.addr;
   assign o_Mem_Wr_Data = req_q.data;
   assign o_Bus_Rd_Data = rd_data_q;

endmodule

// File: tb/tb_shell_bus_responder.sv
// Directed table-driven bench for shell_bus_responder.
// Timeout sequence runs when SHELL_BUS_TIMEOUT_EN is defined.
module tb_shell_bus_responder;

   localparam int RDL = 3;
   localparam int TMO = 16;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        i_Bus_CS = 1'b0;
   logic        i_Bus_Wr_Rd_n = 1'b0;
   logic        i_Bus_Sel = 1'b0;
   logic [15:0] i_Bus_Addr = '0;
   logic [15:0] i_Bus_Wr_Data = '0;
   logic        o_Bus_Busy;
   logic        o_Bus_Rd_DV;
   logic [15:0] o_Bus_Rd_Data;
   logic        o_Bus_Wr_Done;
   logic        o_Bus_Err;
   logic        o_Halt_Req;
   logic        i_Halt_Ack = 1'b1;
   logic [15:0] o_Mem_Addr;
   logic [15:0] o_Mem_Wr_Data;
   logic        o_ROM_We;
   logic        o_RAM_We;
   logic        o_Mem_Re;
   logic [15:0] i_Mem_Rd_Data;

   shell_bus_responder #(
      .RD_LATENCY     (RDL),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .CLK           (CLK),
      .RST           (RST),
      .i_Bus_CS      (i_Bus_CS),
      .i_Bus_Wr_Rd_n (i_Bus_Wr_Rd_n),
      .i_Bus_Sel     (i_Bus_Sel),
      .i_Bus_Addr    (i_Bus_Addr),
      .i_Bus_Wr_Data (i_Bus_Wr_Data),
      .o_Bus_Busy    (o_Bus_Busy),
      .o_Bus_Rd_DV   (o_Bus_Rd_DV),
      .o_Bus_Rd_Data (o_Bus_Rd_Data),
      .o_Bus_Wr_Done (o_Bus_Wr_Done),
      .o_Bus_Err     (o_Bus_Err),
      .o_Halt_Req    (o_Halt_Req),
      .i_Halt_Ack    (i_Halt_Ack),
      .o_Mem_Addr    (o_Mem_Addr),
      .o_Mem_Wr_Data (o_Mem_Wr_Data),
      .o_ROM_We      (o_ROM_We),
      .o_RAM_We      (o_RAM_We),
      .o_Mem_Re      (o_Mem_Re),
      .i_Mem_Rd_Data (i_Mem_Rd_Data)
   );

   always #5 CLK = ~CLK;

   // Memory model: data valid only RDL cycles after the read strobe
   logic [7:0]  re_pipe = '0;
   logic [15:0] mem_val = '0;
   always @(posedge CLK) re_pipe <= {re_pipe[6:0], o_Mem_Re};
   assign i_Mem_Rd_Data = re_pipe[RDL-1] ? mem_val : 16'hDEAD;

   // Strobe bundle: busy halt romwe ramwe re wrdone rddv err
   localparam logic [7:0] B_BUSY = 8'h80;
   localparam logic [7:0] B_HALT = 8'h40;
   localparam logic [7:0] B_ROMW = 8'h20;
   localparam logic [7:0] B_RAMW = 8'h10;
   localparam logic [7:0] B_RE   = 8'h08;
   localparam logic [7:0] B_WRD  = 8'h04;
   localparam logic [7:0] B_RDV  = 8'h02;
   localparam logic [7:0] B_ERR  = 8'h01;

   function automatic logic [7:0] obs();
      return {o_Bus_Busy, o_Halt_Req, o_ROM_We, o_RAM_We,
              o_Mem_Re, o_Bus_Wr_Done, o_Bus_Rd_DV, o_Bus_Err};
   endfunction

   int n_pass = 0;
   int n_total = 0;
   logic [15:0] exp_rd = '0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   typedef struct {
      logic        wr;
      logic        sel;
      logic [15:0] addr;
      logic [15:0] data;
      logic [15:0] mem;
      int          ack_cyc;
      int          extra_cs;
      bit          ack_drop;
   } vec_t;

   vec_t vecs[9];

   function automatic logic [7:0] exp_obs(input vec_t v, input int c);
      int hw;
      int acc;
      int rsp;
      logic [7:0] e;
      hw  = (v.ack_cyc == 0) ? 1 : v.ack_cyc;
      acc = hw + 1;
      rsp = v.wr ? acc + 1 : acc + 1 + RDL;
      e   = '0;
      if (c <= hw) e = B_BUSY | B_HALT;
      else if (c == acc) begin
         e = B_BUSY | B_HALT;
         if (!v.wr) e |= B_RE;
         else if (v.sel) e |= B_RAMW;
         else e |= B_ROMW;
      end
      else if (c < rsp) e = B_BUSY | B_HALT;
      else if (c == rsp) e = B_BUSY | (v.wr ? B_WRD : B_RDV);
      return e;
   endfunction

   // Runs one transaction from a negedge; returns at the first idle negedge
   task automatic run(input vec_t v, input int idx);
      int hw;
      int acc;
      int rsp;
      hw  = (v.ack_cyc == 0) ? 1 : v.ack_cyc;
      acc = hw + 1;
      rsp = v.wr ? acc + 1 : acc + 1 + RDL;
      i_Halt_Ack    = (v.ack_cyc == 0);
      mem_val       = v.mem;
      i_Bus_CS      = 1'b1;
      i_Bus_Wr_Rd_n = v.wr;
      i_Bus_Sel     = v.sel;
      i_Bus_Addr    = v.addr;
      i_Bus_Wr_Data = v.data;
      for (int c = 1; c <= rsp + 1; c++) begin
         @(negedge CLK);
         chk($sformatf("v%0d_c%0d_strobes", idx, c),
             32'(obs()), 32'(exp_obs(v, c)));
         if (c == acc) begin
            chk($sformatf("v%0d_addr", idx), 32'(o_Mem_Addr), 32'(v.addr));
            if (v.wr)
               chk($sformatf("v%0d_wdata", idx), 32'(o_Mem_Wr_Data), 32'(v.data));
         end
         if (c == rsp && !v.wr) exp_rd = v.mem;
         if (c >= rsp)
            chk($sformatf("v%0d_c%0d_rdata", idx, c),
                32'(o_Bus_Rd_Data), 32'(exp_rd));
         if (c == v.ack_cyc) i_Halt_Ack = 1'b1;
         if (v.ack_drop && c == acc) i_Halt_Ack = 1'b0;
         if (c == v.extra_cs && c <= rsp) begin
            i_Bus_CS      = 1'b1;
            i_Bus_Wr_Rd_n = 1'b0;
            i_Bus_Sel     = ~v.sel;
            i_Bus_Addr    = v.addr ^ 16'h5555;
         end else begin
            i_Bus_CS = 1'b0;
         end
      end
   endtask

   initial begin
      //          wr    sel   addr      data      mem       ack ext drop
      vecs[0] = '{1'b1, 1'b1, 16'h0010, 16'hBEEF, 16'h0000, 0,  0,  0};
      vecs[1] = '{1'b0, 1'b0, 16'h0100, 16'h0000, 16'h1234, 0,  0,  0};
      vecs[2] = '{1'b1, 1'b0, 16'hFFFF, 16'h5A5A, 16'h0000, 0,  0,  0};
      vecs[3] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 16'hCAFE, 0,  0,  0};
      vecs[4] = '{1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'h8001, 10, 0,  0};
      vecs[5] = '{1'b1, 1'b1, 16'h7FFF, 16'h0001, 16'h0000, 0,  2,  0};
      vecs[6] = '{1'b0, 1'b0, 16'h0042, 16'h0000, 16'h1357, 0,  4,  1};
      vecs[7] = '{1'b1, 1'b1, 16'h1234, 16'hFFFF, 16'h0000, 0,  3,  0};
      vecs[8] = '{1'b0, 1'b1, 16'h00FF, 16'h0000, 16'h0F0F, 0,  6,  0};

      repeat (2) @(negedge CLK);
      chk("reset_strobes", 32'(obs()), 32'h0);
      chk("reset_rdata", 32'(o_Bus_Rd_Data), 32'h0);
      RST = 1'b1;
      @(negedge CLK);
      chk("post_reset_idle", 32'(obs()), 32'h0);

      for (int i = 0; i < 9; i++) run(vecs[i], i);

`ifdef SHELL_BUS_TIMEOUT_EN
      i_Halt_Ack    = 1'b0;
      i_Bus_CS      = 1'b1;
      i_Bus_Wr_Rd_n = 1'b1;
      i_Bus_Sel     = 1'b1;
      i_Bus_Addr    = 16'h0BAD;
      for (int c = 1; c <= TMO + 2; c++) begin
         @(negedge CLK);
         i_Bus_CS = 1'b0;
         if (c <= TMO)
            chk($sformatf("tmo_wait_c%0d", c), 32'(obs()), 32'(B_BUSY | B_HALT));
         else if (c == TMO + 1)
            chk("tmo_err", 32'(obs()), 32'(B_BUSY | B_ERR));
         else
            chk("tmo_idle", 32'(obs()), 32'h0);
      end
      chk("tmo_rdata_held", 32'(o_Bus_Rd_Data), 32'(exp_rd));
      i_Halt_Ack = 1'b1;
`else
      begin
         vec_t lw;
         lw = '{1'b1, 1'b0, 16'h0ACE, 16'h1111, 16'h0000, 40, 0, 0};
         run(lw, 9);
      end
`endif

      i_Halt_Ack    = 1'b1;
      mem_val       = 16'h4321;
      i_Bus_CS      = 1'b1;
      i_Bus_Wr_Rd_n = 1'b0;
      i_Bus_Sel     = 1'b0;
      i_Bus_Addr    = 16'h0200;
      for (int c = 1; c <= 4; c++) begin
         @(negedge CLK);
         i_Bus_CS = 1'b0;
      end
      chk("midrd_in_wait", 32'(obs()), 32'(B_BUSY | B_HALT));
      RST = 1'b0;
      @(negedge CLK);
      chk("midrd_reset_strobes", 32'(obs()), 32'h0);
      chk("midrd_reset_rdata", 32'(o_Bus_Rd_Data), 32'h0);
      chk("midrd_reset_addr", 32'(o_Mem_Addr), 32'h0);
      RST = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         @(negedge CLK);
         chk($sformatf("midrd_after_c%0d", c), 32'(obs()), 32'h0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
